// File: rtl/gb_cart_responder.sv
// Game Boy cartridge-port responder: input sync, bus-cycle FSM, 6-bit ROM / 4-bit RAM bank mapper.
// Optional macro CART_OPEN_BUS_EN: unmapped reads drive 8'hFF instead of leaving the bus floating.
module gb_cart_responder #(
   parameter int          SYNC_STAGES = 2,
   parameter int          SETTLE_CYC  = 3,
   parameter logic [22:0] RAM_BASE    = 23'h400000,
   parameter logic [5:0]  ROM_MASK    = 6'h3F
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        cart_phi_in,
   input  logic        cart_nwr_in,
   input  logic        cart_nrd_in,
   input  logic        cart_ncs_in,
   input  logic [15:0] cart_addr_in,
   input  logic [7:0]  cart_data_in,
   output logic [7:0]  cart_data_out,
   output logic        cart_data_dir,
   output logic        mem_req,
   output logic        mem_we,
   output logic [22:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic [5:0]  rom_bank,
   output logic [3:0]  ram_bank,
   output logic        ram_en,
   output logic [15:0] phi_count
);

   typedef enum logic [2:0] {IDLE, SETTLE, FETCH, DRIVE, WRITE, WFETCH, OPEN} state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

   state_t state;

   logic [SYNC_STAGES-1:0] nrd_sync, nwr_sync, ncs_sync, phi_sync;
   logic [15:0]            addr_sync [SYNC_STAGES];
   logic [7:0]             data_sync [SYNC_STAGES];

   logic        nrd_s, nwr_s, ncs_s, phi_s;
   logic [15:0] addr_s;
   logic [7:0]  data_s;
   logic        nwr_d, phi_d;

   logic [15:0] addr_q;
   logic [7:0]  settle_cnt;
   logic        rd_abort;
   logic        rd_block;

   logic        rd_hit;
   logic [22:0] rd_maddr;
   logic        wr_ram_hit;
   logic [22:0] wr_maddr;

   // Strobes idle high; address/data chains reset to zero.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         nrd_sync <= '1;
         nwr_sync <= '1;
         ncs_sync <= '1;
         phi_sync <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            addr_sync[i] <= '0;
            data_sync[i] <= '0;
         end
      end else begin
         nrd_sync     <= {nrd_sync[SYNC_STAGES-2:0], cart_nrd_in};
         nwr_sync     <= {nwr_sync[SYNC_STAGES-2:0], cart_nwr_in};
         ncs_sync     <= {ncs_sync[SYNC_STAGES-2:0], cart_ncs_in};
         phi_sync     <= {phi_sync[SYNC_STAGES-2:0], cart_phi_in};
         addr_sync[0] <= cart_addr_in;
         data_sync[0] <= cart_data_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            addr_sync[i] <= addr_sync[i-1];
            data_sync[i] <= data_sync[i-1];
         end
      end
   end

   assign nrd_s  = nrd_sync[SYNC_STAGES-1];
   assign nwr_s  = nwr_sync[SYNC_STAGES-1];
   assign ncs_s  = ncs_sync[SYNC_STAGES-1];
   assign phi_s  = phi_sync[SYNC_STAGES-1];
   assign addr_s = addr_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

   always_comb begin
      rd_hit   = 1'b0;
      rd_maddr = '0;
      if (!addr_q[15]) begin
         rd_hit   = 1'b1;
         rd_maddr = addr_q[14] ? {3'b0, rom_bank, addr_q[13:0]} : {9'b0, addr_q[13:0]};
      end else if (addr_q[15:13] == 3'b101 && !ncs_s && ram_en) begin
         rd_hit   = 1'b1;
         rd_maddr = RAM_BASE + {6'b0, ram_bank, addr_q[12:0]};
      end
      wr_ram_hit = (addr_s[15:13] == 3'b101) && !ncs_s && ram_en;
      wr_maddr   = RAM_BASE + {6'b0, ram_bank, addr_s[12:0]};
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         cart_data_out <= 8'hFF;
         cart_data_dir <= 1'b0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         rom_bank      <= 6'd1;
         ram_bank      <= 4'd0;
         ram_en        <= 1'b0;
         phi_count     <= '0;
         phi_d         <= 1'b0;
         nwr_d         <= 1'b1;
         addr_q        <= '0;
         settle_cnt    <= '0;
         rd_abort      <= 1'b0;
         rd_block      <= 1'b0;
      end else if (!enable) begin
         state         <= IDLE;
         cart_data_out <= 8'hFF;
         cart_data_dir <= 1'b0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         rom_bank      <= 6'd1;
         ram_bank      <= 4'd0;
         ram_en        <= 1'b0;
         phi_count     <= '0;
         phi_d         <= phi_s;
         nwr_d         <= nwr_s;
         addr_q        <= '0;
         settle_cnt    <= '0;
         rd_abort      <= 1'b0;
         rd_block      <= 1'b0;
      end else begin
         phi_d <= phi_s;
         nwr_d <= nwr_s;
         if (phi_s && !phi_d)
            phi_count <= phi_count + 16'd1;
         // A read overlapping a write is ignored until both strobes return high.
         if (nrd_s && nwr_s)
            rd_block <= 1'b0;

         case (state)
            IDLE: begin
               cart_data_dir <= 1'b0;
               if (!nwr_s) begin
                  rd_block <= 1'b1;
                  state    <= WRITE;
               end else if (!nrd_s && !rd_block) begin
                  addr_q     <= addr_s;
                  settle_cnt <= '0;
                  state      <= SETTLE;
               end
            end

            SETTLE: begin
               if (!nwr_s || nrd_s) begin
                  state <= IDLE;
               end else if (addr_s != addr_q) begin
                  addr_q     <= addr_s;
                  settle_cnt <= '0;
               end else if (settle_cnt == SETTLE_LAST) begin
                  if (rd_hit) begin
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= rd_maddr;
                     rd_abort <= 1'b0;
                     state    <= FETCH;
                  end else begin
`ifdef CART_OPEN_BUS_EN
                     cart_data_out <= 8'hFF;
                     cart_data_dir <= 1'b1;
`endif
                     state <= OPEN;
                  end
               end else begin
                  settle_cnt <= settle_cnt + 8'd1;
               end
            end

            // The memory request is always completed; a released /RD only discards the data.
            FETCH: begin
               if (nrd_s)
                  rd_abort <= 1'b1;
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (rd_abort || nrd_s) begin
                     state <= IDLE;
                  end else begin
                     cart_data_out <= mem_rdata;
                     cart_data_dir <= 1'b1;
                     state         <= DRIVE;
                  end
               end
            end

            DRIVE: begin
               if (nrd_s || addr_s != addr_q) begin
                  cart_data_dir <= 1'b0;
                  state         <= IDLE;
               end
            end

            OPEN: begin
               if (nrd_s || addr_s != addr_q) begin
                  cart_data_dir <= 1'b0;
                  state         <= IDLE;
               end
            end

            WRITE: begin
               cart_data_dir <= 1'b0;
               if (nwr_s && !nwr_d) begin
                  case (addr_s[15:13])
                     3'b000: ram_en   <= (data_s[3:0] == 4'hA);
                     3'b001: rom_bank <= ((data_s[5:0] == 6'd0) ? 6'd1 : data_s[5:0]) & ROM_MASK;
                     3'b010: ram_bank <= data_s[3:0];
                     default: ;
                  endcase
                  if (wr_ram_hit) begin
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b1;
                     mem_addr  <= wr_maddr;
                     mem_wdata <= data_s;
                     state     <= WFETCH;
                  end else begin
                     state <= IDLE;
                  end
               end
            end

            WFETCH: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gb_cart_responder.sv
// Directed bench for gb_cart_responder: reads, bank writes, RAM write, unmapped read, aborts, reset.
module tb_gb_cart_responder;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        cart_phi_in;
   logic        cart_nwr_in;
   logic        cart_nrd_in;
   logic        cart_ncs_in;
   logic [15:0] cart_addr_in;
   logic [7:0]  cart_data_in;
   logic [7:0]  cart_data_out;
   logic        cart_data_dir;
   logic        mem_req;
   logic        mem_we;
   logic [22:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   logic [5:0]  rom_bank;
   logic [3:0]  ram_bank;
   logic        ram_en;
   logic [15:0] phi_count;

   int checks = 0;
   int errors = 0;

   always #5 clk_sys = ~clk_sys;

   gb_cart_responder dut (
      .clk_sys       (clk_sys),
      .reset_n       (reset_n),
      .enable        (enable),
      .cart_phi_in   (cart_phi_in),
      .cart_nwr_in   (cart_nwr_in),
      .cart_nrd_in   (cart_nrd_in),
      .cart_ncs_in   (cart_ncs_in),
      .cart_addr_in  (cart_addr_in),
      .cart_data_in  (cart_data_in),
      .cart_data_out (cart_data_out),
      .cart_data_dir (cart_data_dir),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_ack       (mem_ack),
      .rom_bank      (rom_bank),
      .ram_bank      (ram_bank),
      .ram_en        (ram_en),
      .phi_count     (phi_count)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic wait_req(input string tag, input int budget);
      int n = 0;
      while (mem_req !== 1'b1 && n < budget) begin
         step(1);
         n++;
      end
      check({tag, "_req"}, 32'(mem_req), 32'd1);
   endtask

   task automatic ack(input logic [7:0] d);
      mem_rdata = d;
      mem_ack   = 1'b1;
      step(1);
      mem_ack   = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [15:0] a, input logic [22:0] exp_addr,
                          input logic [7:0] d);
      cart_addr_in = a;
      cart_nrd_in  = 1'b0;
      wait_req(tag, 30);
      check({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
      check({tag, "_we"}, 32'(mem_we), 32'd0);
      check({tag, "_nodir"}, 32'(cart_data_dir), 32'd0);
      ack(d);
      check({tag, "_dir"}, 32'(cart_data_dir), 32'd1);
      check({tag, "_data"}, 32'(cart_data_out), 32'(d));
      check({tag, "_reqdrop"}, 32'(mem_req), 32'd0);
      cart_nrd_in = 1'b1;
      step(3);
      check({tag, "_release"}, 32'(cart_data_dir), 32'd0);
      step(2);
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic cs);
      cart_addr_in = a;
      cart_data_in = d;
      cart_ncs_in  = cs;
      cart_nwr_in  = 1'b0;
      step(4);
      cart_nwr_in  = 1'b1;
      step(3);
   endtask

   initial begin
      logic seen_req;
      reset_n      = 1'b0;
      enable       = 1'b1;
      cart_phi_in  = 1'b0;
      cart_nwr_in  = 1'b1;
      cart_nrd_in  = 1'b1;
      cart_ncs_in  = 1'b1;
      cart_addr_in = 16'h0000;
      cart_data_in = 8'h00;
      mem_rdata    = 8'h00;
      mem_ack      = 1'b0;
      step(3);
      check("rst_data", 32'(cart_data_out), 32'hFF);
      check("rst_dir", 32'(cart_data_dir), 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_rom_bank", 32'(rom_bank), 32'd1);
      check("rst_ram_bank", 32'(ram_bank), 32'd0);
      check("rst_ram_en", 32'(ram_en), 32'd0);
      check("rst_phi", 32'(phi_count), 32'd0);
      reset_n = 1'b1;
      step(2);

      for (int i = 0; i < 8; i++) begin
         cart_phi_in = 1'b1;
         step(2);
         cart_phi_in = 1'b0;
         step(2);
      end
      step(3);
      check("phi_count", 32'(phi_count), 32'd8);

      do_read("rd0150", 16'h0150, 23'h000150, 8'h3C);

      do_write(16'h2000, 8'h00, 1'b1);
      check("bank_zero_maps_1", 32'(rom_bank), 32'd1);
      do_read("rd4000", 16'h4000, 23'h004000, 8'h11);
      do_write(16'h2000, 8'h25, 1'b1);
      check("bank_25", 32'(rom_bank), 32'h25);
      do_read("rd7fff", 16'h7FFF, 23'h097FFF, 8'hA5);
      do_write(16'h3FFF, 8'hC5, 1'b1);
      check("bank_upper_bits", 32'(rom_bank), 32'h05);

      do_write(16'h0000, 8'h0A, 1'b1);
      check("ram_en_on", 32'(ram_en), 32'd1);
      do_write(16'h4000, 8'h02, 1'b1);
      check("ram_bank_2", 32'(ram_bank), 32'd2);
      do_write(16'hA010, 8'h5A, 1'b0);
      check("wr_req", 32'(mem_req), 32'd1);
      check("wr_we", 32'(mem_we), 32'd1);
      check("wr_addr", 32'(mem_addr), 32'h404010);
      check("wr_data", 32'(mem_wdata), 32'h5A);
      check("wr_dir", 32'(cart_data_dir), 32'd0);
      ack(8'h00);
      check("wr_reqdrop", 32'(mem_req), 32'd0);
      step(2);
      do_read("rdA010", 16'hA010, 23'h404010, 8'h5A);
      cart_ncs_in = 1'b1;
      do_write(16'h1000, 8'h00, 1'b1);
      check("ram_en_off", 32'(ram_en), 32'd0);

      cart_ncs_in  = 1'b0;
      cart_addr_in = 16'hA010;
      cart_nrd_in  = 1'b0;
      seen_req = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         seen_req = seen_req | mem_req;
      end
      check("open_noreq", 32'(seen_req), 32'd0);
`ifdef CART_OPEN_BUS_EN
      check("open_dir", 32'(cart_data_dir), 32'd1);
      check("open_data", 32'(cart_data_out), 32'hFF);
`else
      check("open_dir", 32'(cart_data_dir), 32'd0);
`endif
      cart_nrd_in = 1'b1;
      step(4);
      check("open_release", 32'(cart_data_dir), 32'd0);
      cart_ncs_in = 1'b1;

      // Address moves early in the settle window: only the new address may be requested.
      cart_addr_in = 16'h0100;
      cart_nrd_in  = 1'b0;
      step(2);
      cart_addr_in = 16'h0101;
      wait_req("resettle", 30);
      check("resettle_addr", 32'(mem_addr), 32'h000101);
      ack(8'h77);
      check("resettle_data", 32'(cart_data_out), 32'h77);
      cart_nrd_in = 1'b1;
      step(5);

      cart_addr_in = 16'h0200;
      cart_nrd_in  = 1'b0;
      wait_req("abort", 30);
      cart_nrd_in = 1'b1;
      step(6);
      check("abort_req_held", 32'(mem_req), 32'd1);
      check("abort_nodir", 32'(cart_data_dir), 32'd0);
      ack(8'h99);
      check("abort_reqdrop", 32'(mem_req), 32'd0);
      check("abort_dir", 32'(cart_data_dir), 32'd0);
      step(3);
      check("abort_dir_late", 32'(cart_data_dir), 32'd0);

      do_write(16'h2000, 8'h25, 1'b1);
      cart_addr_in = 16'h0300;
      cart_nrd_in  = 1'b0;
      wait_req("rstdrv", 30);
      ack(8'h42);
      check("rstdrv_dir", 32'(cart_data_dir), 32'd1);
      reset_n     = 1'b0;
      cart_nrd_in = 1'b1;
      #1;
      check("rstdrv_dir0", 32'(cart_data_dir), 32'd0);
      check("rstdrv_req0", 32'(mem_req), 32'd0);
      check("rstdrv_bank", 32'(rom_bank), 32'd1);
      #1;
      reset_n = 1'b1;
      step(3);

      do_write(16'h2000, 8'h07, 1'b1);
      check("bank_7", 32'(rom_bank), 32'd7);
      enable = 1'b0;
      step(1);
      check("disable_bank", 32'(rom_bank), 32'd1);
      check("disable_dir", 32'(cart_data_dir), 32'd0);
      enable = 1'b1;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
